// File: rtl/write_back_if.sv
// Writeback stage bus: execute result bundle in, register-file / PC / UART TX out.
// The slave modport is the writeback stage's view; master is the surrounding pipeline.
interface write_back_if #(
  parameter int unsigned OUT_DEPTH = 16
) ();
  localparam int unsigned CntW = $clog2(OUT_DEPTH) + 1;

  logic            enable;
  logic [3:0]      wselector;
  logic [31:0]     data;
  logic [4:0]      rd;
  logic [31:0]     pc_target;
  logic            done;
  logic [31:0]     pc;
  logic            reg_we;
  logic [4:0]      reg_waddr;
  logic [31:0]     reg_wdata;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic [CntW-1:0] out_count;

  modport master (
    output enable, wselector, data, rd, pc_target, out_ready,
    input  done, pc, reg_we, reg_waddr, reg_wdata, out_data, out_valid, out_count
  );

  modport slave (
    input  enable, wselector, data, rd, pc_target, out_ready,
    output done, pc, reg_we, reg_waddr, reg_wdata, out_data, out_valid, out_count
  );
endinterface

// File: rtl/write_back.sv
// Writeback stage: register-file write, PC update and OUT byte FIFO towards the UART.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module write_back #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0] instret,
`endif
  write_back_if.slave bus
);
  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWaitOut} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              done_q, done_d;
  logic              reg_we_q, reg_we_d;
  logic [4:0]        reg_waddr_q, reg_waddr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        mem_q [OUT_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic       pop, room, push;
  logic [7:0] push_byte;
  logic       unused_sel;

  assign unused_sel = bus.wselector[0];

  assign pop  = (count_q != '0) && bus.out_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign room = (count_q < CntW'(OUT_DEPTH)) || pop;

  // Next-state: writeback actions in IDLE, push retry while stalled on OUT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    done_d      = 1'b0;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    hold_d      = hold_q;
    push        = 1'b0;
    push_byte   = hold_q;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          if (bus.wselector[1] && (bus.rd != 5'd0)) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = bus.rd;
            reg_wdata_d = bus.data;
          end
          pc_d   = bus.wselector[2] ? bus.pc_target : pc_q + 32'd4;
          done_d = 1'b1;
          if (bus.wselector[3]) begin
            push_byte = bus.data[7:0];
            if (room) begin
              push = 1'b1;
            end else begin
              hold_d  = bus.data[7:0];
              done_d  = 1'b0;
              state_d = StWaitOut;
            end
          end
        end
      end
      StWaitOut: begin
        if (room) begin
          push    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  // State, outputs and FIFO pointers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      done_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= 32'd0;
      hold_q      <= 8'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      done_q      <= done_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= push_byte;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret_q;

  // Retired-op counter follows the done pulse.
  always_ff @(posedge clk) begin
    if (rst) instret_q <= 64'd0;
    else     instret_q <= instret_q + 64'(done_q);
  end

  assign instret = instret_q;
`endif

  assign bus.done      = done_q;
  assign bus.pc        = pc_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign bus.out_count = count_q;

  // A new bundle while stalled on OUT would be lost.
  a_no_enable_in_wait: assert property (@(posedge clk) disable iff (rst)
    (state_q == StWaitOut) |-> !bus.enable)
    else $error("write_back: enable asserted while waiting on OUT FIFO");

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed table, corner sequences, random vs model.
module tb_write_back;
  localparam int unsigned Depth = 16;
  localparam logic [31:0] ResetPc = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_back_if #(.OUT_DEPTH(Depth)) bus_if ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  write_back #(.RESET_PC(ResetPc), .OUT_DEPTH(Depth)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef WB_RETIRE_CNT_EN
    .instret (instret),
`endif
    .bus     (bus_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [7:0]  m_q[$];
  logic        m_stalled;
  logic [7:0]  m_hold;
  logic        m_done, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [63:0] m_instret;

  typedef struct {
    logic        en;
    logic [3:0]  ws;
    logic [31:0] d;
    logic [4:0]  rd;
    logic [31:0] tgt;
    logic        exp_done;
    logic        exp_we;
    logic        chk_w;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = ResetPc;
    m_q.delete();
    m_stalled = 1'b0;
    m_hold = 8'h0;
    m_done = 1'b0;
    m_we = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
    m_instret = 64'd0;
  endtask

  task automatic check_all();
    chk("done", bus_if.done, m_done);
    chk("reg_we", bus_if.reg_we, m_we);
    chk("pc", bus_if.pc, m_pc);
    chk("reg_waddr", bus_if.reg_waddr, m_waddr);
    chk("reg_wdata", bus_if.reg_wdata, m_wdata);
    chk("out_count", bus_if.out_count, m_q.size());
    chk("out_valid", bus_if.out_valid, m_q.size() != 0);
    chk("out_data", bus_if.out_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
`ifdef WB_RETIRE_CNT_EN
    chk("instret", instret, m_instret);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.enable = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  // One clock of stimulus, model update, then compare all outputs.
  task automatic cycle(input logic en, input logic [3:0] ws, input logic [31:0] d,
                       input logic [4:0] rd, input logic [31:0] tgt, input logic rdy);
    logic pop, room, push, nd, nwe;
    logic [7:0] pb;
    bus_if.enable    = en;
    bus_if.wselector = ws;
    bus_if.data      = d;
    bus_if.rd        = rd;
    bus_if.pc_target = tgt;
    bus_if.out_ready = rdy;
    pop  = (m_q.size() != 0) && rdy;
    room = (m_q.size() < Depth) || pop;
    push = 1'b0;
    nd   = 1'b0;
    nwe  = 1'b0;
    pb   = 8'h0;
    if (m_stalled) begin
      if (room) begin
        push = 1'b1;
        pb = m_hold;
        m_stalled = 1'b0;
        nd = 1'b1;
      end
    end else if (en) begin
      nwe = ws[1] && (rd != 5'd0);
      if (nwe) begin
        m_waddr = rd;
        m_wdata = d;
      end
      m_pc = ws[2] ? tgt : m_pc + 32'd4;
      nd = 1'b1;
      if (ws[3]) begin
        if (room) begin
          push = 1'b1;
          pb = d[7:0];
        end else begin
          m_stalled = 1'b1;
          m_hold = d[7:0];
          nd = 1'b0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(pb);
    m_instret = m_instret + 64'(m_done);
    m_done = nd;
    m_we = nwe;
    step();
    if (bus_if.done === 1'b1) n_done++;
    check_all();
  endtask

  initial begin
    int done0;
    rst = 1'b1;
    bus_if.enable = 1'b0;
    bus_if.wselector = 4'h0;
    bus_if.data = 32'h0;
    bus_if.rd = 5'd0;
    bus_if.pc_target = 32'h0;
    bus_if.out_ready = 1'b0;
    step();
    do_reset();
    chk("rst_pc", bus_if.pc, ResetPc);
    chk("rst_done", bus_if.done, 1'b0);
    chk("rst_valid", bus_if.out_valid, 1'b0);

    // Directed table: jump to 0x100, ALU write, JAL, r0 write, PC wrap.
    tbl[0] = '{1'b1, 4'b0100, 32'h0, 5'd0, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h100};
    tbl[1] = '{1'b1, 4'b0010, 32'h12345678, 5'd5, 32'h0, 1'b1, 1'b1, 1'b1, 5'd5,
               32'h12345678, 32'h104};
    tbl[2] = '{1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678,
               32'h104};
    tbl[3] = '{1'b1, 4'b0110, 32'h108, 5'd31, 32'h40, 1'b1, 1'b1, 1'b1, 5'd31, 32'h108,
               32'h40};
    tbl[4] = '{1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd31, 32'h108, 32'h40};
    tbl[5] = '{1'b1, 4'b0110, 32'h108, 5'd0, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h40};
    tbl[6] = '{1'b1, 4'b0100, 32'h0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
               32'hFFFFFFFC};
    tbl[7] = '{1'b1, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
    tbl[8] = '{1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].en, tbl[i].ws, tbl[i].d, tbl[i].rd, tbl[i].tgt, 1'b0);
      chk($sformatf("tbl%0d_done", i), bus_if.done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_we", i), bus_if.reg_we, tbl[i].exp_we);
      chk($sformatf("tbl%0d_pc", i), bus_if.pc, tbl[i].exp_pc);
      if (tbl[i].chk_w) begin
        chk($sformatf("tbl%0d_waddr", i), bus_if.reg_waddr, tbl[i].exp_waddr);
        chk($sformatf("tbl%0d_wdata", i), bus_if.reg_wdata, tbl[i].exp_wdata);
      end
    end

    // OUT drain: 41, 42, 43 with ready held high.
    done0 = n_done;
    cycle(1'b1, 4'b1000, 32'h41, 5'd0, 32'h0, 1'b1);
    chk("drain_first", bus_if.out_data, 8'h41);
    cycle(1'b1, 4'b1000, 32'h42, 5'd0, 32'h0, 1'b1);
    chk("drain_second", bus_if.out_data, 8'h42);
    cycle(1'b1, 4'b1000, 32'h43, 5'd0, 32'h0, 1'b1);
    chk("drain_third", bus_if.out_data, 8'h43);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1);
    chk("drain_empty", bus_if.out_count, 0);
    chk("drain_dones", n_done - done0, 3);

    // Fill the FIFO, stall on the 17th byte, then release with one ready cycle.
    for (int i = 0; i < Depth; i++) cycle(1'b1, 4'b1000, 32'(i), 5'd0, 32'h0, 1'b0);
    chk("full_count", bus_if.out_count, Depth);
    cycle(1'b1, 4'b1000, 32'h5A, 5'd0, 32'h0, 1'b0);
    chk("stall_nodone", bus_if.done, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("stall_hold_nodone", bus_if.done, 1'b0);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1);
    chk("release_done", bus_if.done, 1'b1);
    chk("release_count", bus_if.out_count, Depth);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("release_single", bus_if.done, 1'b0);
    for (int i = 0; i < Depth - 1; i++) cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1);
    chk("tail_byte", bus_if.out_data, 8'h5A);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1);
    chk("tail_empty", bus_if.out_valid, 1'b0);

    // Reset while stalled.
    for (int i = 0; i < Depth + 1; i++) cycle(1'b1, 4'b1000, 32'h60 + 32'(i), 5'd0, 32'h0, 1'b0);
    chk("stall2_nodone", bus_if.done, 1'b0);
    do_reset();
    chk("mid_rst_valid", bus_if.out_valid, 1'b0);
    chk("mid_rst_count", bus_if.out_count, 0);
    chk("mid_rst_pc", bus_if.pc, ResetPc);
    chk("mid_rst_done", bus_if.done, 1'b0);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b1);
    chk("mid_rst_nodone", bus_if.done, 1'b0);

`ifdef WB_RETIRE_CNT_EN
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 4'b0000, 32'h0, 5'd0, 32'h0, 1'b0);
    chk("instret_five", instret, 64'd5);
    do_reset();
    chk("instret_rst", instret, 64'd0);
`endif

    // Random traffic against the model; never enable while a byte is held.
    for (int i = 0; i < 600; i++) begin
      logic en;
      logic [4:0] rd;
      en = ($urandom_range(0, 2) != 0) && !m_stalled;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      cycle(en, 4'($urandom), $urandom, rd, $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
